// File: rtl/prog_loader_pkg.sv
// prog_loader shared definitions: loader state encoding, frame constants and
// the length-byte decode (a length byte of 0 stands for a full 256-byte frame).
// Optional build macro used by the loader: PROG_LOADER_VERIFY_EN.
package prog_loader_pkg;

  // Default frame start marker.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Remaining-count width: must hold 256, the largest frame.
  localparam int unsigned CNT_W = 9;

  // Length-byte value 0 encodes a full-RAM frame of this many bytes.
  localparam logic [CNT_W-1:0] FULL_FRAME_LEN = 9'd256;

  // Loader states. VERIFY_RD / VERIFY_CK / DRAIN are only reachable when the
  // read-back verify feature is built in.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_LEN       = 4'd2,
    ST_DATA      = 4'd3,
    ST_WRITE     = 4'd4,
    ST_CSUM      = 4'd5,
    ST_VERIFY_RD = 4'd6,
    ST_VERIFY_CK = 4'd7,
    ST_DRAIN     = 4'd8
  } state_t;

  // Turn the frame length byte into the number of payload bytes to expect.
  function automatic logic [CNT_W-1:0] decode_len(input logic [7:0] len_byte);
    return (len_byte == 8'd0) ? FULL_FRAME_LEN : {1'b0, len_byte};
  endfunction

endpackage

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream program loader into the 256x8 system RAM (optional read-back verify: PROG_LOADER_VERIFY_EN).
// Latency: one RAM write per payload byte, 2 cycles/byte (4 with verify); cpu_halt/done/error update the cycle after the accepting edge.
// Backpressure: in_ready drops while a write (or verify read) is in flight; no combinational path from in_valid to any output.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] ram_addr,
  output logic       ram_we,
  output logic [7:0] ram_wdata,
  output logic       ram_drive,
  output logic       ram_oe,
  input  logic [7:0] ram_rdata,
  output logic       cpu_halt,
  output logic       done,
  output logic       error
);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [7:0]       ptr_q,   ptr_d;    // next RAM address to write
  logic [CNT_W-1:0] cnt_q,   cnt_d;    // payload bytes still to commit
  logic [7:0]       sum_q,   sum_d;    // running payload checksum
  logic [7:0]       byte_q,  byte_d;   // payload byte being written
  logic             halt_q,  halt_d;
  logic             done_q,  done_d;
  logic             error_q, error_d;

  logic xfer;
  assign xfer = in_valid && in_ready;

`ifndef PROG_LOADER_VERIFY_EN
  // Without verify the read-back bus is not used at all.
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
`endif

  // Output decode from registered state only.
  always_comb begin
    in_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = 8'd0;
    ram_wdata = 8'd0;
    ram_oe    = 1'b0;
    case (state_q)
      // Byte-consuming states; held off while reset is asserted.
      ST_IDLE, ST_ADDR, ST_LEN, ST_DATA, ST_CSUM: in_ready = !reset;
      ST_WRITE: begin
        ram_we    = 1'b1;
        ram_addr  = ptr_q;
        ram_wdata = byte_q;
      end
`ifdef PROG_LOADER_VERIFY_EN
      // RAM samples the read address on the edge that leaves VERIFY_RD.
      ST_VERIFY_RD: begin
        ram_oe   = 1'b1;
        ram_addr = ptr_q;
      end
      // Registered read data is on ram_rdata during this state.
      ST_VERIFY_CK: ram_oe = 1'b1;
      ST_DRAIN:     in_ready = !reset;
`endif
      default: ;
    endcase
    // The tristate driver is enabled exactly when we are writing.
    ram_drive = ram_we;
  end

  assign cpu_halt = halt_q;
  assign done     = done_q;
  assign error    = error_q;

  // Next-state and datapath updates for the frame parser.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    byte_d  = byte_q;
    halt_d  = halt_q;
    done_d  = done_q;
    error_d = error_q;

    case (state_q)
      // Hunt for the frame marker; anything else is dropped.
      ST_IDLE: begin
        if (xfer && (in_data == SYNC_BYTE)) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          halt_d  = 1'b1;
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (xfer) begin
          ptr_d   = in_data;
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (xfer) begin
          cnt_d   = decode_len(in_data);
          sum_d   = 8'd0;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (xfer) begin
          byte_d  = in_data;
          sum_d   = sum_q + in_data;
          state_d = ST_WRITE;
        end
      end

      // Write cycle. With verify the byte is only committed (pointer and
      // count stepped) once its read-back has matched.
      ST_WRITE: begin
`ifdef PROG_LOADER_VERIFY_EN
        state_d = ST_VERIFY_RD;
`else
        ptr_d   = ptr_q + 8'd1;
        cnt_d   = cnt_q - 9'd1;
        state_d = (cnt_q == 9'd1) ? ST_CSUM : ST_DATA;
`endif
      end

      // Trailing checksum decides the final status and releases the CPU.
      ST_CSUM: begin
        if (xfer) begin
          if (in_data == sum_q) begin
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          halt_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

`ifdef PROG_LOADER_VERIFY_EN
      ST_VERIFY_RD: state_d = ST_VERIFY_CK;

      ST_VERIFY_CK: begin
        if (ram_rdata != byte_q) begin
          // cnt_q still counts this byte, so it equals the remaining
          // payload bytes plus the checksum: exactly what DRAIN must eat.
          error_d = 1'b1;
          halt_d  = 1'b0;
          state_d = ST_DRAIN;
        end else begin
          ptr_d   = ptr_q + 8'd1;
          cnt_d   = cnt_q - 9'd1;
          state_d = (cnt_q == 9'd1) ? ST_CSUM : ST_DATA;
        end
      end

      // Swallow the rest of a failed frame so the stream stays aligned.
      ST_DRAIN: begin
        if (xfer) begin
          cnt_d = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any load and clears all status at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 8'd0;
      cnt_q   <= '0;
      sum_q   <= 8'd0;
      byte_q  <= 8'd0;
      halt_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      byte_q  <= byte_d;
      halt_q  <= halt_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed and randomized frames against a RAM image model.
// Latency expectations: 2 cycles per payload byte (4 with PROG_LOADER_VERIFY_EN).
// Backpressure: the host side waits on in_ready with a bounded cycle budget.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic       ram_drive;
  logic       ram_oe;
  logic [7:0] ram_rdata;
  logic       cpu_halt;
  logic       done;
  logic       error;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_drive (ram_drive),
    .ram_oe    (ram_oe),
    .ram_rdata (ram_rdata),
    .cpu_halt  (cpu_halt),
    .done      (done),
    .error     (error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Behavioural RAM seen by the loader, plus the expected image.
  logic [7:0] tb_ram    [256];
  logic [7:0] model_ram [256];
  bit         model_vld [256];
  logic [7:0] rdata_q;
  logic       stuck = 1'b0;
  int         we_cnt = 0;
  bit         gaps_en = 1'b0;

  assign ram_rdata = stuck ? 8'h00 : rdata_q;

  always @(posedge clk) begin
    if (ram_we) begin
      tb_ram[ram_addr] <= ram_wdata;
      we_cnt++;
    end
    if (ram_oe) rdata_q <= tb_ram[ram_addr];
  end

  // Bus-level invariants sampled mid-cycle.
  always @(negedge clk) begin
    check("drive_eq_we", ram_drive, ram_we);
    check("done_error_excl", done & error, 0);
    if (ram_we) check("rdy_low_in_write", in_ready, 0);
    if (!cpu_halt) check("bus_idle_unhalted", {ram_we, ram_oe, ram_addr, ram_wdata}, 0);
`ifndef PROG_LOADER_VERIFY_EN
    check("oe_tied_low", ram_oe, 0);
`endif
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

`ifdef PROG_LOADER_VERIFY_EN
  localparam int CYC_PER_BYTE = 4;
`else
  localparam int CYC_PER_BYTE = 2;
`endif

  // Offer one byte; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int waitc = 0;
    @(negedge clk);
    if (gaps_en) begin
      while ($urandom_range(0, 2) == 0) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waitc < 64) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      check("rdy_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic check_ram(input string nm);
    int mism = 0;
    for (int a = 0; a < 256; a++)
      if (model_vld[a] && (tb_ram[a] !== model_ram[a])) mism++;
    check({"ram_", nm}, mism, 0);
  endtask

  // Full frame: sync, address, length, payload, checksum; all expectations
  // come from the frame contents.
  task automatic run_frame(input string nm, input logic [7:0] addr, input logic [7:0] len_byte,
                           input logic [7:0] pl [$], input logic [7:0] csum);
    int   n     = (len_byte == 0) ? 256 : int'(len_byte);
    int   total = 0;
    int   we0   = we_cnt;
    time  t0    = 0;
    time  t1    = 0;
    bit   good;
    for (int i = 0; i < n; i++) total += int'(pl[i]);
    good = (csum == 8'(total % 256));
    check({"halt_pre_", nm}, cpu_halt, 0);
    send_byte(8'hA5);
    check({"halt_rise_", nm}, cpu_halt, 1);
    check({"status_clr_", nm}, {done, error}, 2'b00);
    send_byte(addr);
    send_byte(len_byte);
    for (int i = 0; i < n; i++) begin
      send_byte(pl[i]);
      if (i == 0) t0 = $time;
      t1 = $time;
      model_ram[(int'(addr) + i) % 256] = pl[i];
      model_vld[(int'(addr) + i) % 256] = 1'b1;
    end
    if (!gaps_en && n > 1) check({"thruput_", nm}, 32'((t1 - t0) / 10), 32'((n - 1) * CYC_PER_BYTE));
    check({"halt_mid_", nm}, cpu_halt, 1);
    send_byte(csum);
    check({"halt_fall_", nm}, cpu_halt, 0);
    check({"done_", nm}, done, good);
    check({"error_", nm}, error, !good);
    check({"we_pulses_", nm}, we_cnt - we0, n);
    check_ram(nm);
  endtask

  logic [7:0] pl [$];
  logic [7:0] p0, p1;
  int         we_r;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_outputs", {ram_we, ram_drive, ram_oe, ram_addr, ram_wdata, cpu_halt, done, error}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_release_ready", in_ready, 1);

    // Basic load.
    pl = '{8'h11, 8'h22, 8'h33};
    run_frame("basic", 8'h10, 8'h03, pl, 8'h66);
    check("basic_ram10", tb_ram[8'h10], 8'h11);
    check("basic_ram12", tb_ram[8'h12], 8'h33);

    // Address wrap 0xFF -> 0x00.
    pl = '{8'h01, 8'h02, 8'h03};
    run_frame("wrap", 8'hFE, 8'h03, pl, 8'h06);
    check("wrap_ram00", tb_ram[8'h00], 8'h03);

    // Leading junk is discarded, then a bad checksum.
    send_byte(8'h00);
    send_byte(8'hFF);
    check("junk_no_halt", cpu_halt, 0);
    pl = '{8'h7E};
    run_frame("badsum", 8'h20, 8'h01, pl, 8'h7F);
    check("badsum_ram20", tb_ram[8'h20], 8'h7E);

    // Full 256-byte frame via length byte 0.
    pl.delete();
    for (int i = 0; i < 256; i++) pl.push_back(8'(i));
    run_frame("full", 8'h00, 8'h00, pl, 8'h80);

    // Reset after the second payload byte aborts the load.
    we_r = we_cnt;
    p0 = 8'($urandom);
    p1 = 8'($urandom);
    send_byte(8'hA5);
    send_byte(8'h30);
    send_byte(8'h05);
    send_byte(p0);
    send_byte(p1);
    reset = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_outputs", {ram_we, ram_drive, ram_oe, ram_addr, ram_wdata, cpu_halt, done, error}, 0);
    model_ram[8'h30] = p0;
    model_vld[8'h30] = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ready_back", in_ready, 1);
    check("abort_we_pulses", we_cnt - we_r, 1);
    pl = '{8'hA5, 8'h5A};
    run_frame("post_abort", 8'h30, 8'h02, pl, 8'hFF);

`ifdef PROG_LOADER_VERIFY_EN
    // Read-back stuck at zero: error, CPU released, rest of frame drained.
    stuck = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h40);
    send_byte(8'h03);
    send_byte(8'h55);
    model_ram[8'h40] = 8'h55;
    model_vld[8'h40] = 1'b1;
    repeat (4) @(negedge clk);
    check("vfy_error", error, 1);
    check("vfy_done", done, 0);
    check("vfy_halt_drop", cpu_halt, 0);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h12);
    stuck = 1'b0;
    check("vfy_status_held", {done, error}, 2'b01);
    pl = '{8'h01};
    run_frame("vfy_recover", 8'h41, 8'h01, pl, 8'h01);
`endif

    // Randomized frames with random backpressure gaps and junk.
    gaps_en = 1'b1;
    for (int f = 0; f < 24; f++) begin
      logic [7:0] a, ln, cs;
      int s = 0;
      int nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) send_byte(8'($urandom_range(0, 8'hA4)));
      a  = 8'($urandom);
      ln = 8'($urandom_range(1, 20));
      pl.delete();
      for (int i = 0; i < int'(ln); i++) begin
        pl.push_back(($urandom_range(0, 5) == 0) ? 8'hA5 : 8'($urandom));
        s += int'(pl[i]);
      end
      cs = 8'(s % 256);
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      run_frame($sformatf("rnd%0d", f), a, ln, pl, cs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Upstream feeder for the 256×8 system RAM. Receives a framed program image as a byte stream over a valid/ready handshake and writes it into RAM through the shared address/data/write-enable bus. Holds the CPU in halt for the duration of the load, then reports success or failure. Owns the RAM bus only while `cpu_halt` is high; the top level muxes bus ownership on that signal.

## Interface
- `SYNC_BYTE`, 8'hA5, frame start marker
- `clk`  in  1  system clock, all state changes on posedge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `in_valid`  in  1  host byte available
- `in_data`  in  8  host byte
- `in_ready`  out  1  loader can accept `in_data` this cycle
- `ram_addr`  out  8  RAM address
- `ram_we`  out  1  RAM write enable, one-cycle pulse per byte
- `ram_wdata`  out  8  data driven onto the RAM data bus
- `ram_drive`  out  1  top level enables the tristate driver of `ram_wdata` when high; equals `ram_we`
- `ram_oe`  out  1  RAM output enable (verify reads only)
- `ram_rdata`  in  8  RAM data bus as seen by the loader
- `cpu_halt`  out  1  CPU held; loader owns the RAM bus
- `done`  out  1  sticky: last frame loaded and checksum matched
- `error`  out  1  sticky: last frame failed

## Operation
- A byte transfers on a posedge where `in_valid && in_ready`.
- Frame format: `SYNC_BYTE`, start address, length (0 encodes 256), payload bytes, checksum. The checksum is the 8-bit sum mod 256 of all payload bytes.
- States:
  - IDLE (`in_ready`=1): bytes other than `SYNC_BYTE` are discarded. On `SYNC_BYTE`: clear `done`/`error`, set `cpu_halt`, go to ADDR.
  - ADDR: latch address pointer, go to LEN.
  - LEN: latch 9-bit remaining count (0→256), clear the running sum, go to DATA.
  - DATA (`in_ready`=1): latch byte, add it to the sum, go to WRITE.
  - WRITE (`in_ready`=0): `ram_we`=`ram_drive`=1, `ram_addr`=pointer, `ram_wdata`=byte. Then: pointer+1 (8-bit wrap, 0xFF→0x00), count−1. Next state is VERIFY_RD if enabled; otherwise DATA while count≠0, else CSUM.
  - CSUM (`in_ready`=1): byte equal to sum → `done`=1; otherwise `error`=1. Drop `cpu_halt`, go to IDLE.
- `done` and `error` are mutually exclusive. They hold until the next `SYNC_BYTE` is accepted or `reset`.
- A `SYNC_BYTE` value inside ADDR/LEN/DATA/CSUM is ordinary data, with no resync.
- RAM bus outputs are 0 in every state not listed as driving them.

## Timing
- Reset values: `in_ready`=0 while `reset` is high, 1 (IDLE) after release. `ram_we`=`ram_drive`=`ram_oe`=0, `ram_addr`=0, `ram_wdata`=0, `cpu_halt`=0, `done`=0, `error`=0.
- All outputs are registered or decoded from registered state; there is no combinational path from `in_valid` to any output.
- Throughput: one payload byte per 2 cycles without verify, per 4 cycles with verify.
- `cpu_halt` rises the cycle after the sync byte is accepted. It falls the cycle after the checksum byte is accepted.
- `reset` mid-frame aborts the load. No partial status is kept, `cpu_halt` drops, and RAM contents already written stay.

## Configuration
- `PROG_LOADER_VERIFY_EN` defined:
  - After each WRITE, go to VERIFY_RD (`ram_oe`=1, `ram_we`=0, `ram_addr`=written address). The RAM registers the read on this edge.
  - Then go to VERIFY_CK (`ram_oe`=1) and compare `ram_rdata` with the written byte.
  - Mismatch → `error`=1, `cpu_halt`=0, go to DRAIN. DRAIN discards the remaining payload and checksum bytes (`in_ready`=1), then returns to IDLE.
  - Match → continue as for WRITE.
- Undefined: no VERIFY/DRAIN states, `ram_oe` tied 0, `ram_rdata` unused.

## Structure
- Shared package: state enum, `SYNC_BYTE` default, frame-length encoding constant (0→256).
- Single module; no sub-module. Checksum and counter logic are small enough to stay inline.

## Test plan
- Frame A5 10 03 11 22 33 66 → RAM[0x10..0x12]=11,22,33; `done`=1, `error`=0, `cpu_halt` low afterwards.
- Frame A5 FE 03 01 02 03 06 → writes 0xFE, 0xFF, 0x00 (wrap); `done`=1.
- Bytes 00 FF then frame A5 20 01 7E 7F → 00, FF discarded, RAM[0x20]=7E; bad checksum gives `error`=1, `done`=0.
- Length byte 00 with 256 payload bytes, each value i, and checksum 0x80 → full RAM written; exactly 256 `ram_we` pulses.
- `reset` asserted after the 2nd payload byte → all outputs return to reset values immediately. A following valid frame loads normally.
- With `PROG_LOADER_VERIFY_EN`, force `ram_rdata` stuck at 0x00 on a write of 0x55 → `error`=1, remaining bytes drained, IDLE reached.
